seq_mult_param: RTL and testbench
=================================

// Module: seq_mult_param
// PURPOSE
//  Parametrised radix-2 shift-add sequential multiplier: WIDTH x WIDTH -> 2*WIDTH.
//  Each transaction is unsigned or signed two's complement, chosen by in_signed.
//  Valid/ready handshake on input and output sides, with output backpressure.
//  Drop-in successor to the fixed 8-bit start/ready multiplier in the lab datapaths.
// PARAMETERS
//  WIDTH  8                  operand width in bits, >= 2
//  CNT_W  $clog2(WIDTH+1)    localparam, iteration counter width (derived, not overridable)
// PORTS
//  clk        input   1         rising-edge clock
//  rst_n      input   1         synchronous reset, active-low
//  in_valid   input   1         operands a, b, in_signed valid
//  in_ready   output  1         block can accept operands; high only in IDLE
//  in_signed  input   1         1 = signed two's complement, 0 = unsigned
//  a          input   WIDTH     multiplicand
//  b          input   WIDTH     multiplier
//  out_valid  output  1         product valid
//  out_ready  input   1         consumer accepts product
//  product    output  2*WIDTH   result
//  busy       output  1         state != IDLE
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state=IDLE, product=0, out_valid=0, busy=0, count=0, in_ready=1.
//    Reset has priority over everything else.
//    Reset mid-CALC/FIX/DONE aborts the operation; no result is emitted.
//  - FSM states:
//    IDLE -> CALC  on in_valid & in_ready.
//      Latch mcand = |a| and acc = {WIDTH'0, |b|}; |x| is applied only when in_signed=1, else the raw value is used.
//      Latch neg = in_signed & (a[W-1] ^ b[W-1]). Set count=0.
//    CALC, one iteration per cycle:
//      If acc[0]: acc[2W-1:W-1] <= acc[2W-1:W] + mcand (W+1-bit sum, carry kept), and acc[W-2:0] <= acc[W-1:1].
//      Else: acc <= acc >> 1.
//      count++. After WIDTH iterations -> FIX.
//    FIX (1 cycle): product <= neg ? -acc : acc (2*WIDTH-bit two's-complement negate) -> DONE.
//    DONE: out_valid=1. Go to IDLE on out_valid & out_ready.
//  - Latency: out_valid rises WIDTH+1 rising edges after the accepting edge (W=8: 9 edges).
//    Min issue interval is WIDTH+3 cycles. in_ready is low in CALC, FIX and DONE.
//  - Backpressure: in DONE with out_ready=0, product and out_valid hold indefinitely.
//    Input pulses are ignored while in_ready=0.
//  - product holds its last value after the output handshake until the next FIX.
//    out_valid is 0 outside DONE.
//  - Sign edge cases:
//    |-2^(W-1)| = 2^(W-1) fits unsigned in W bits, so (-2^(W-1))^2 is exact.
//    A zero operand with neg=1 yields 0, since -0 = 0.
//  - Operand inputs are sampled only on the accepting edge; later changes do not affect the result.
//  - in_signed=0 with MSB-set operands is treated as pure unsigned.
// STRUCTURE
//  - Package seq_mult_pkg:
//    2-bit state typedef {IDLE, CALC, FIX, DONE};
//    DEFAULT_WIDTH constant.
//  - Sub-module seq_mult_step (combinational, param WIDTH): one shift-add iteration,
//    (acc, mcand) -> next acc. The top-level holds the FSM, counter, sign and negate logic.
// TESTING  (WIDTH=8 unless stated)
//  1. Unsigned 200*150 -> product=0x7530; out_valid exactly 9 edges after accept; in_ready=0 throughout.
//  2. Signed -3*5 -> 0xFFF1. Same bits unsigned 0xFD*5 -> 0x04F1.
//     Signed -128*-128 -> 0x4000. Signed 127*-128 -> 0xC080.
//  3. Corners: unsigned 255*255 -> 0xFE01; signed 0*-1 -> 0x0000; unsigned 1*1 -> 0x0001.
//  4. Backpressure: hold out_ready=0 for 20 cycles in DONE and pulse in_valid.
//     -> out_valid, product stable; no accept.
//     Raise out_ready -> IDLE next edge; in_ready=1.
//  5. Reset mid-CALC at iteration 4 -> next cycle out_valid=0, product=0, in_ready=1, busy=0.
//     Then 7*9 -> 0x003F.
//  6. WIDTH=16: 1000 back-to-back random signed/unsigned ops with random out_ready,
//     compared against a behavioural a*b model. Zero mismatches; no lost or duplicated results.

Source files
------------

// File: rtl/seq_mult_pkg.sv
// Shared definitions for the shift-add sequential multiplier.
//   DEFAULT_WIDTH : default operand width
//   state_t       : controller state encoding
package seq_mult_pkg;

   localparam int unsigned DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/seq_mult_step.sv
// One radix-2 shift-add iteration (purely combinational).
// Ports:
//   acc      in   2*WIDTH  partial product; low half holds remaining multiplier bits
//   mcand    in   WIDTH    multiplicand magnitude
//   acc_next out  2*WIDTH  accumulator after this iteration
module seq_mult_step
   import seq_mult_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic [2*WIDTH-1:0] acc,
   input  logic [WIDTH-1:0]   mcand,
   output logic [2*WIDTH-1:0] acc_next
);

   logic [WIDTH:0] sum;

   always_comb begin
      // Carry out of the upper-half add lands in the top bit as the shift happens.
      sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
      if (acc[0]) begin
         acc_next = {sum, acc[WIDTH-1:1]};
      end else begin
         acc_next = acc >> 1;
      end
   end

endmodule

// File: rtl/seq_mult_param.sv
// Parametrised radix-2 shift-add sequential multiplier, WIDTH x WIDTH -> 2*WIDTH,
// unsigned or signed two's complement per transaction, valid/ready on both sides.
// Ports:
//   clk        in   1        rising-edge clock
//   rst_n      in   1        synchronous reset, active-low
//   in_valid   in   1        operands valid
//   in_ready   out  1        operands accepted (IDLE only)
//   in_signed  in   1        1 = signed operands, 0 = unsigned
//   a, b       in   WIDTH    multiplicand, multiplier
//   out_valid  out  1        product valid (DONE only)
//   out_ready  in   1        consumer accepts product
//   product    out  2*WIDTH  result, held until the next FIX
//   busy       out  1        not IDLE
module seq_mult_param
   import seq_mult_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_signed,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] product,
   output logic               busy
);

   localparam int unsigned     CNT_W     = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   state_t               state_q, state_d;
   logic [2*WIDTH-1:0]   acc_q, acc_next;
   logic [WIDTH-1:0]     mcand_q;
   logic                 neg_q;
   logic [CNT_W-1:0]     count_q;
   logic [2*WIDTH-1:0]   product_q;
   logic [WIDTH-1:0]     a_mag, b_mag;

   // Magnitudes; -2^(W-1) maps to 2^(W-1), which is still exact as unsigned.
   always_comb begin
      a_mag = (in_signed && a[WIDTH-1]) ? -a : a;
      b_mag = (in_signed && b[WIDTH-1]) ? -b : b;
   end

   seq_mult_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .acc      (acc_q),
      .mcand    (mcand_q),
      .acc_next (acc_next)
   );

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (in_valid) state_d = CALC;
         CALC:    if (count_q == LAST_ITER) state_d = FIX;
         FIX:     state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
      busy      = (state_q != IDLE);
      product   = product_q;
   end

   // Datapath
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_q     <= '0;
         mcand_q   <= '0;
         neg_q     <= 1'b0;
         count_q   <= '0;
         product_q <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (in_valid) begin
                  mcand_q <= a_mag;
                  acc_q   <= {{WIDTH{1'b0}}, b_mag};
                  neg_q   <= in_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                  count_q <= '0;
               end
            end
            CALC: begin
               acc_q   <= acc_next;
               count_q <= count_q + CNT_W'(1);
            end
            FIX:     product_q <= neg_q ? -acc_q : acc_q;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_mult_param.sv
// Bench for seq_mult_param: directed vector table and corner sequences at WIDTH=8,
// plus a randomised scoreboard run at WIDTH=16.
module tb_seq_mult_param;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // WIDTH=8 instance
   logic        in_valid8, in_ready8, in_signed8, out_valid8, out_ready8, busy8;
   logic [7:0]  a8, b8;
   logic [15:0] product8;

   // WIDTH=16 instance
   logic        in_valid16, in_ready16, in_signed16, out_valid16, out_ready16, busy16;
   logic [15:0] a16, b16;
   logic [31:0] product16;

   seq_mult_param #(.WIDTH(8)) dut8 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid8),
      .in_ready  (in_ready8),
      .in_signed (in_signed8),
      .a         (a8),
      .b         (b8),
      .out_valid (out_valid8),
      .out_ready (out_ready8),
      .product   (product8),
      .busy      (busy8)
   );

   seq_mult_param #(.WIDTH(16)) dut16 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid16),
      .in_ready  (in_ready16),
      .in_signed (in_signed16),
      .a         (a16),
      .b         (b16),
      .out_valid (out_valid16),
      .out_ready (out_ready16),
      .product   (product16),
      .busy      (busy16)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0] q8[$];
   logic [31:0] q16[$];

   typedef struct {
      logic        sgn;
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] exp;
      string       name;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // One full transaction on the 8-bit instance with out_ready held high.
   task automatic run_op8(input logic sgn, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] exp, input string name);
      int          edges;
      logic        held;
      logic [15:0] want;
      in_signed8 = sgn;
      a8         = a;
      b8         = b;
      in_valid8  = 1'b1;
      @(negedge clk);
      check({name, " in_ready"}, 32'(in_ready8), 32'd1);
      q8.push_back(exp);
      @(posedge clk);
      #1;
      // Scramble operands after the accepting edge; they must not matter.
      in_valid8  = 1'b0;
      a8         = 8'($urandom);
      b8         = 8'($urandom);
      in_signed8 = ~sgn;
      edges      = 0;
      held       = 1'b1;
      while (!out_valid8 && edges < 40) begin
         @(posedge clk);
         #1;
         edges++;
         if (in_ready8 || !busy8) held = 1'b0;
      end
      check({name, " latency"}, 32'(edges), 32'd9);
      check({name, " in_ready low"}, 32'(held), 32'd1);
      if (q8.size() > 0) begin
         want = q8.pop_front();
         check({name, " product"}, 32'(product8), 32'(want));
      end
      @(posedge clk);
      #1;
   endtask

   int          bp_i;
   logic        stable;
   int          w;
   logic [15:0] ra, rb;
   logic        rs;
   longint      sa, sb;
   logic [63:0] full;
   int          rcv16;
   int          cyc;
   logic [31:0] want16;
   logic [15:0] want8;

   initial begin
      vecs[0] = '{1'b0, 8'd200, 8'd150, 16'h7530, "u200x150"};
      vecs[1] = '{1'b1, 8'hFD,  8'd5,   16'hFFF1, "s-3x5"};
      vecs[2] = '{1'b0, 8'hFD,  8'd5,   16'h04F1, "uFDx5"};
      vecs[3] = '{1'b1, 8'h80,  8'h80,  16'h4000, "s-128x-128"};
      vecs[4] = '{1'b1, 8'h7F,  8'h80,  16'hC080, "s127x-128"};
      vecs[5] = '{1'b0, 8'hFF,  8'hFF,  16'hFE01, "u255x255"};
      vecs[6] = '{1'b1, 8'h00,  8'hFF,  16'h0000, "s0x-1"};
      vecs[7] = '{1'b0, 8'h01,  8'h01,  16'h0001, "u1x1"};

      rst_n       = 1'b0;
      in_valid8   = 1'b0;
      in_signed8  = 1'b0;
      a8          = '0;
      b8          = '0;
      out_ready8  = 1'b1;
      in_valid16  = 1'b0;
      in_signed16 = 1'b0;
      a16         = '0;
      b16         = '0;
      out_ready16 = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check("reset product", 32'(product8), 32'd0);
      check("reset out_valid", 32'(out_valid8), 32'd0);
      check("reset busy", 32'(busy8), 32'd0);
      check("reset in_ready", 32'(in_ready8), 32'd1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 8; i++) begin
         run_op8(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);
      end

      // Backpressure: result must hold in DONE while inputs pulse.
      out_ready8 = 1'b0;
      run_bp_start();
      stable = 1'b1;
      for (bp_i = 0; bp_i < 20; bp_i++) begin
         in_valid8 = bp_i[0];
         a8        = 8'($urandom);
         b8        = 8'($urandom);
         @(posedge clk);
         #1;
         if (!(out_valid8 && busy8 && !in_ready8 && product8 == 16'h009C)) stable = 1'b0;
      end
      check("bp stable", 32'(stable), 32'd1);
      in_valid8 = 1'b0;
      want8 = (q8.size() > 0) ? q8.pop_front() : 16'hDEAD;
      check("bp product", 32'(product8), 32'(want8));
      out_ready8 = 1'b1;
      @(posedge clk);
      #1;
      check("bp release in_ready", 32'(in_ready8), 32'd1);
      check("bp release out_valid", 32'(out_valid8), 32'd0);
      check("bp release busy", 32'(busy8), 32'd0);
      check("bp product held", 32'(product8), 32'h009C);

      // Reset during CALC after 4 iterations.
      in_signed8 = 1'b0;
      a8         = 8'd100;
      b8         = 8'd100;
      in_valid8  = 1'b1;
      @(posedge clk);
      #1;
      in_valid8 = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("midcalc busy", 32'(busy8), 32'd1);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("abort out_valid", 32'(out_valid8), 32'd0);
      check("abort product", 32'(product8), 32'd0);
      check("abort in_ready", 32'(in_ready8), 32'd1);
      check("abort busy", 32'(busy8), 32'd0);
      stable = 1'b1;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (out_valid8 || busy8) stable = 1'b0;
      end
      check("abort no result", 32'(stable), 32'd1);
      run_op8(1'b0, 8'd7, 8'd9, 16'h003F, "u7x9");

      // WIDTH=16 random scoreboard run.
      rcv16 = 0;
      fork
         begin
            for (int i = 0; i < 1000; i++) begin
               ra = 16'($urandom);
               rb = 16'($urandom);
               if ($urandom_range(0, 15) == 0) ra = 16'h8000;
               if ($urandom_range(0, 15) == 0) rb = 16'h8000;
               rs = 1'($urandom_range(0, 1));
               sa = rs ? longint'($signed(ra)) : longint'(ra);
               sb = rs ? longint'($signed(rb)) : longint'(rb);
               full = 64'(sa * sb);
               in_signed16 = rs;
               a16         = ra;
               b16         = rb;
               in_valid16  = 1'b1;
               w = 0;
               @(negedge clk);
               while (!in_ready16 && w < 200) begin
                  @(negedge clk);
                  w++;
               end
               if (!in_ready16) begin
                  check("rand accept timeout", 32'd0, 32'd1);
                  break;
               end
               q16.push_back(full[31:0]);
               @(posedge clk);
               #1;
            end
            in_valid16 = 1'b0;
         end
         begin
            cyc = 0;
            while (rcv16 < 1000 && cyc < 40000) begin
               @(negedge clk);
               if (out_valid16 && out_ready16) begin
                  if (q16.size() == 0) begin
                     check("rand duplicate", 32'd1, 32'd0);
                  end else begin
                     want16 = q16.pop_front();
                     check("rand product", product16, want16);
                  end
                  rcv16++;
               end
               @(posedge clk);
               #1;
               out_ready16 = ($urandom_range(0, 3) != 0);
               cyc++;
            end
         end
      join
      check("rand received", 32'(rcv16), 32'd1000);
      check("rand leftover", 32'(q16.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Issue 12*13 unsigned and wait (bounded) for DONE.
   task automatic run_bp_start();
      int edges;
      in_signed8 = 1'b0;
      a8         = 8'd12;
      b8         = 8'd13;
      in_valid8  = 1'b1;
      @(negedge clk);
      check("bp in_ready", 32'(in_ready8), 32'd1);
      q8.push_back(16'h009C);
      @(posedge clk);
      #1;
      in_valid8 = 1'b0;
      edges = 0;
      while (!out_valid8 && edges < 40) begin
         @(posedge clk);
         #1;
         edges++;
      end
      check("bp latency", 32'(edges), 32'd9);
   endtask

endmodule
